// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared constants and helpers for the memory responder
package mem_responder_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = 4;

  // A word access is bad if misaligned or if its last byte falls past the store.
  function automatic logic addr_bad(input logic [31:0] addr, input int addr_w);
    logic [32:0] limit;
    limit = (33'd1 << addr_w) - 33'd3;
    return (addr[1:0] != 2'b00) || ({1'b0, addr} >= limit);
  endfunction

endpackage

// File: rtl/mem_responder_byte_ram.sv
// rtl/mem_responder_byte_ram.sv - big-endian four-lane byte store, synchronous, no reset
module byte_ram
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int WORDS = (1 << ADDR_W) / WORD_BYTES;

  // Lane 0 holds the byte at addr+0, which sits in bits 31:24.
  logic [7:0] lane0 [0:WORDS-1];
  logic [7:0] lane1 [0:WORDS-1];
  logic [7:0] lane2 [0:WORDS-1];
  logic [7:0] lane3 [0:WORDS-1];

  logic [ADDR_W-3:0] word;
  logic              unused_low;

  assign word       = addr[ADDR_W-1:2];
  assign unused_low = ^addr[1:0];

  always_ff @(posedge clk) begin
    if (we[3]) lane0[word] <= wdata[31:24];
    if (we[2]) lane1[word] <= wdata[23:16];
    if (we[1]) lane2[word] <= wdata[15:8];
    if (we[0]) lane3[word] <= wdata[7:0];
    rdata <= {lane0[word], lane1[word], lane2[word], lane3[word]};
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding memory responder with programmable wait states
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              lat_write;
  logic              lat_err;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [3:0]        lat_be;

  logic              in_idle;
  logic              req_err;
  logic              enter_resp;
  logic              acc_write;
  logic              acc_err;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_we;
  logic [31:0]       ram_rdata;

  assign in_idle = (state == IDLE);
  assign req_err = addr_bad(req_addr, ADDR_W);

  // With zero wait states the accepting edge is also the access edge, so the
  // RAM is fed straight from the request port while idle.
  assign acc_write = in_idle ? req_write : lat_write;
  assign acc_err   = in_idle ? req_err   : lat_err;
  assign acc_wdata = in_idle ? req_wdata : lat_wdata;
  assign acc_be    = in_idle ? req_be    : lat_be;
  assign ram_addr  = in_idle ? req_addr[ADDR_W-1:0] : lat_addr;

  assign enter_resp = reset &&
                      ((in_idle && req_valid && (WAIT_LOAD == '0)) ||
                       ((state == WAIT) && (cnt <= CNT_W'(1))));

  assign ram_we = (enter_resp && acc_write && !acc_err) ? acc_be : 4'b0000;

  byte_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_err   <= req_err;
            lat_addr  <= req_addr[ADDR_W-1:0];
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            cnt       <= WAIT_LOAD;
            state     <= (WAIT_LOAD != '0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) state <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The RAM re-reads the latched address every cycle and is never written in
  // RESP, so the read word stays stable for the whole response phase.
  assign req_ready = in_idle;
  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_valid && lat_err;
  assign rsp_rdata = (rsp_valid && !lat_write && !lat_err) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cur   = 0;

  logic        req_valid_a, req_ready_a, req_write_a, rsp_valid_a, rsp_ready_a, rsp_err_a;
  logic [31:0] req_addr_a, req_wdata_a, rsp_rdata_a;
  logic [3:0]  req_be_a;
  logic        req_valid_z, req_ready_z, req_write_z, rsp_valid_z, rsp_ready_z, rsp_err_z;
  logic [31:0] req_addr_z, req_wdata_z, rsp_rdata_z;
  logic [3:0]  req_be_z;

  logic        obs_req_ready, obs_rsp_valid, obs_rsp_err;
  logic [31:0] obs_rsp_rdata;

  assign obs_req_ready = (cur == 0) ? req_ready_a : req_ready_z;
  assign obs_rsp_valid = (cur == 0) ? rsp_valid_a : rsp_valid_z;
  assign obs_rsp_err   = (cur == 0) ? rsp_err_a   : rsp_err_z;
  assign obs_rsp_rdata = (cur == 0) ? rsp_rdata_a : rsp_rdata_z;

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write_a),
    .req_addr(req_addr_a), .req_wdata(req_wdata_a), .req_be(req_be_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
    .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
  );

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut_z (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write_z),
    .req_addr(req_addr_z), .req_wdata(req_wdata_z), .req_be(req_be_z),
    .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z),
    .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (sel == 0) begin
      req_valid_a = v; req_write_a = w; req_addr_a = a; req_wdata_a = d; req_be_a = be;
    end else begin
      req_valid_z = v; req_write_z = w; req_addr_z = a; req_wdata_z = d; req_be_z = be;
    end
  endtask

  task automatic set_rr(input int sel, input logic v);
    if (sel == 0) rsp_ready_a = v;
    else          rsp_ready_z = v;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, obs_req_ready, 32'd1);
    check({tag, "_rsp_valid"}, obs_rsp_valid, 32'd0);
    check({tag, "_rsp_rdata"}, obs_rsp_rdata, 32'd0);
    check({tag, "_rsp_err"},   obs_rsp_err,   32'd0);
  endtask

  // One full request/response. Request fields are scrambled right after the
  // accepting edge so a responder that fails to latch them gets caught.
  task automatic txn(input string tag, input int sel, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be, input int hold,
                     input logic early, input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    int exp_lat;
    cur     = sel;
    exp_lat = (sel == 0) ? 3 : 1;
    @(negedge clk);
    check({tag, "_req_ready"}, obs_req_ready, 32'd1);
    drive(sel, 1'b1, w, a, d, be);
    set_rr(sel, early);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, ~w, 32'h0000_0014, ~d, ~be);
    for (lat = 1; lat <= 20; lat++) begin
      @(negedge clk);
      if (obs_rsp_valid) break;
    end
    check({tag, "_latency"}, lat, exp_lat);
    if (!obs_rsp_valid) begin
      set_rr(sel, 1'b0);
      return;
    end
    check({tag, "_rdata"}, obs_rsp_rdata, exp_rdata);
    check({tag, "_err"},   obs_rsp_err,   exp_err);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, obs_rsp_valid, 32'd1);
      check({tag, "_hold_rdata"}, obs_rsp_rdata, exp_rdata);
      check({tag, "_hold_err"},   obs_rsp_err,   exp_err);
      check({tag, "_hold_ready"}, obs_req_ready, 32'd0);
    end
    set_rr(sel, 1'b1);
    @(posedge clk);
    #1;
    set_rr(sel, 1'b0);
    check({tag, "_done_valid"}, obs_rsp_valid, 32'd0);
    check({tag, "_done_ready"}, obs_req_ready, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rsp_ready_a = 1'b0;
    rsp_ready_z = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    cur = 0; check_idle_outputs("rst_a");
    cur = 1; check_idle_outputs("rst_z");

    // Full-word write and readback, then byte-lane merge.
    txn("wr10",  0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0, 1'b0);
    txn("rd10",  0, 1'b0, 32'h10, 32'h0,        4'hF, 0, 1'b0, 32'hDEADBEEF, 1'b0);
    txn("wrbe",  0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 0, 1'b0, 32'h0, 1'b0);
    txn("rdbe",  0, 1'b0, 32'h10, 32'h0,        4'hF, 0, 1'b0, 32'hDE22BE44, 1'b0);
    txn("wrbe0", 0, 1'b1, 32'h10, 32'h0,        4'h0, 0, 1'b0, 32'h0, 1'b0);
    txn("rdbe0", 0, 1'b0, 32'h10, 32'h0,        4'hF, 0, 1'b1, 32'hDE22BE44, 1'b0);

    // Error cases: misaligned read, out-of-range write that would alias to 0x00.
    txn("rdmis", 0, 1'b0, 32'h13, 32'h0,        4'hF, 0, 1'b0, 32'h0, 1'b1);
    txn("wr00",  0, 1'b1, 32'h00, 32'h01020304, 4'hF, 0, 1'b0, 32'h0, 1'b0);
    txn("wroor", 0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 0, 1'b0, 32'h0, 1'b1);
    txn("rd00",  0, 1'b0, 32'h00, 32'h0,        4'hF, 0, 1'b0, 32'h01020304, 1'b0);
    txn("wrfc",  0, 1'b1, 32'hFC, 32'h55AA55AA, 4'hF, 0, 1'b0, 32'h0, 1'b0);
    txn("rdfc",  0, 1'b0, 32'hFC, 32'h0,        4'hF, 0, 1'b0, 32'h55AA55AA, 1'b0);
    txn("rdfd",  0, 1'b0, 32'hFD, 32'h0,        4'hF, 0, 1'b0, 32'h0, 1'b1);

    // Backpressure in RESP.
    txn("bp",    0, 1'b0, 32'h10, 32'h0,        4'hF, 5, 1'b0, 32'hDE22BE44, 1'b0);

    // Reset during WAIT of a write discards it.
    txn("wr20",  0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, 1'b0, 32'h0, 1'b0);
    cur = 0;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("midwait_req_ready", obs_req_ready, 32'd0);
    check("midwait_rsp_valid", obs_rsp_valid, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check_idle_outputs("arst_wait");
    @(negedge clk);
    reset = 1'b1;
    txn("rd20",  0, 1'b0, 32'h20, 32'h0,        4'hF, 0, 1'b0, 32'hCAFEF00D, 1'b0);

    // Zero wait states: one-edge latency; a write already performed survives reset.
    txn("z_wr40", 1, 1'b1, 32'h40, 32'hA5A5A5A5, 4'hF, 0, 1'b0, 32'h0, 1'b0);
    txn("z_rd40", 1, 1'b0, 32'h40, 32'h0,        4'hF, 2, 1'b0, 32'hA5A5A5A5, 1'b0);
    cur = 1;
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 32'h40, 32'h5A5A5A5A, 4'b1100);
    @(posedge clk);
    #1;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("z_inresp_valid", obs_rsp_valid, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_idle_outputs("arst_resp");
    @(negedge clk);
    reset = 1'b1;
    txn("z_rd40b", 1, 1'b0, 32'h40, 32'h0,       4'hF, 0, 1'b0, 32'h5A5AA5A5, 1'b0);
    txn("z_rdmis", 1, 1'b0, 32'h42, 32'h0,       4'hF, 0, 1'b0, 32'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
